// File: rtl/operacional_multi.sv
// operacional_multi: door-lock controller with user code table, master code and escalating lockout.
// Optional intrusion alarm: define ALARME_INTRUSAO_EN.
module operacional_multi #(
   parameter int NUM_DIGITOS = 4,
   parameter int NUM_SENHAS = 4,
   parameter logic [4*NUM_DIGITOS-1:0] SENHA_MASTER = 'h1234,
   parameter int MAX_TENT = 5,
   parameter int DEBOUNCE = 10,
   parameter int FECHAR_AUT = 100,
   parameter int BIPAR = 200,
   parameter int DURACAO_ERRO = 50,
   parameter int BLOQ_BASE = 1000,
   parameter int BLOQ_MAX_SHIFT = 3,
   parameter int CNT_W = 16,
   localparam int SW = 4*NUM_DIGITOS,
   localparam int IDX_W = (NUM_SENHAS > 1) ? $clog2(NUM_SENHAS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sensor_contato,
   input  logic             botao_interno,
   input  logic             botao_bloqueio,
   input  logic [SW-1:0]    senha_value,
   input  logic             senha_valid,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [SW-1:0]    cfg_data,
   output logic             teclado_en,
   output logic             tranca,
   output logic             bip,
   output logic [2:0]       tent,
   output logic [23:0]      bcd_pac
);

   localparam int NIV_W = (BLOQ_MAX_SHIFT > 0) ? $clog2(BLOQ_MAX_SHIFT + 1) : 1;
   localparam logic [23:0] BCD_VAZIO = 24'hBBBBBB;
   localparam logic [23:0] BCD_TRACO = 24'hAAAAAA;

   typedef enum logic [3:0] {
      S_RESET,
      S_TRANCADA,
      S_VALIDAR,
      S_ERRADA,
      S_BLOQ,
      S_ENCOSTADA,
      S_ABERTA,
      S_BIP_ABERTA,
      S_BIP_INCOMP,
      S_DEBOUNCE,
      S_NAO_PERT
`ifdef ALARME_INTRUSAO_EN
      , S_ALARME
`endif
   } estado_t;

   estado_t          r_estado;
   estado_t          r_alvo;
   estado_t          r_origem;
   logic             r_fonte;
   logic [CNT_W-1:0] r_cont;
   logic [2:0]       r_tent;
   logic [NIV_W-1:0] r_niv;
   logic [SW-1:0]    r_senha;
   logic [SW-1:0]    r_slots [NUM_SENHAS];
`ifdef ALARME_INTRUSAO_EN
   logic             r_de_alarme;
`endif

   estado_t          w_prox;
   estado_t          w_alvo;
   logic             w_fonte;
   logic             w_btn;
   logic             w_incomp;
   logic             w_master;
   logic             w_hit_slot;
   logic             w_acerto;
   logic             w_fim_bloq;
   logic [CNT_W-1:0] w_bloq_len;
   logic [23:0]      w_tracos;

   assign w_btn      = r_fonte ? botao_bloqueio : botao_interno;
   assign w_incomp   = (senha_value[3:0] == 4'hE);
   assign w_master   = (r_senha == SENHA_MASTER);
   assign w_acerto   = w_master | w_hit_slot;
   assign w_bloq_len = CNT_W'(BLOQ_BASE) << r_niv;
   assign w_fim_bloq = (r_estado == S_BLOQ) && (w_prox == S_TRANCADA);

   // A slot holding all-F digits is disabled and never matches
   always_comb begin
      w_hit_slot = 1'b0;
      for (int i = 0; i < NUM_SENHAS; i++) begin
         if ((r_slots[i] != '1) && (r_slots[i] == r_senha))
            w_hit_slot = 1'b1;
      end
   end

   always_comb begin
      w_tracos = BCD_VAZIO;
      for (int i = 0; i < 6; i++) begin
         if (i < int'(r_tent))
            w_tracos[4*i +: 4] = 4'hA;
      end
   end

   always_comb begin
      w_prox  = r_estado;
      w_alvo  = S_TRANCADA;
      w_fonte = 1'b0;
      case (r_estado)
         S_RESET:
            if (!sensor_contato)
               w_prox = S_TRANCADA;
         S_TRANCADA:
            if (senha_valid && w_incomp)
               w_prox = S_BIP_INCOMP;
            else if (botao_bloqueio) begin
               w_prox  = S_DEBOUNCE;
               w_alvo  = S_NAO_PERT;
               w_fonte = 1'b1;
            end else if (botao_interno) begin
               w_prox = S_DEBOUNCE;
               w_alvo = S_ENCOSTADA;
            end else if (senha_valid)
               w_prox = S_VALIDAR;
         S_VALIDAR: begin
            w_prox = w_acerto ? S_ENCOSTADA : S_ERRADA;
`ifdef ALARME_INTRUSAO_EN
            if (r_de_alarme)
               w_prox = w_master ? S_ENCOSTADA : S_ALARME;
`endif
         end
         S_ERRADA:
            if (r_cont == CNT_W'(DURACAO_ERRO - 1))
               w_prox = (r_tent < 3'(MAX_TENT)) ? S_TRANCADA : S_BLOQ;
         S_BLOQ:
            if (r_cont == w_bloq_len - CNT_W'(1))
               w_prox = S_TRANCADA;
         S_ENCOSTADA:
            if (botao_interno) begin
               w_prox = S_DEBOUNCE;
               w_alvo = S_TRANCADA;
            end else if (sensor_contato)
               w_prox = S_ABERTA;
            else if (r_cont == CNT_W'(FECHAR_AUT - 1))
               w_prox = S_TRANCADA;
         S_ABERTA:
            if (!sensor_contato)
               w_prox = S_ENCOSTADA;
            else if (r_cont == CNT_W'(BIPAR - 1))
               w_prox = S_BIP_ABERTA;
         S_BIP_ABERTA:
            if (!sensor_contato)
               w_prox = S_ENCOSTADA;
         S_BIP_INCOMP:
            if (r_cont == CNT_W'(DURACAO_ERRO - 1))
               w_prox = S_TRANCADA;
         S_DEBOUNCE:
            if (!w_btn)
               w_prox = r_origem;
            else if (r_cont == CNT_W'(DEBOUNCE - 1))
               w_prox = r_alvo;
         S_NAO_PERT:
            if (botao_interno) begin
               w_prox = S_DEBOUNCE;
               w_alvo = S_ENCOSTADA;
            end
`ifdef ALARME_INTRUSAO_EN
         S_ALARME:
            if (senha_valid)
               w_prox = S_VALIDAR;
`endif
         default:
            w_prox = S_RESET;
      endcase
`ifdef ALARME_INTRUSAO_EN
      if (sensor_contato && ((r_estado == S_TRANCADA) ||
          (r_estado == S_BLOQ) || (r_estado == S_NAO_PERT)))
         w_prox = S_ALARME;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_estado <= S_RESET;
         r_cont   <= '0;
         r_alvo   <= S_TRANCADA;
         r_origem <= S_TRANCADA;
         r_fonte  <= 1'b0;
         r_senha  <= '0;
      end else begin
         r_estado <= w_prox;
         r_cont   <= (w_prox != r_estado) ? '0 : r_cont + CNT_W'(1);
         if ((w_prox == S_DEBOUNCE) && (r_estado != S_DEBOUNCE)) begin
            r_alvo   <= w_alvo;
            r_origem <= r_estado;
            r_fonte  <= w_fonte;
         end
         if (w_prox == S_VALIDAR)
            r_senha <= senha_value;
      end
   end

`ifdef ALARME_INTRUSAO_EN
   always_ff @(posedge clk) begin
      if (!rst)
         r_de_alarme <= 1'b0;
      else if (w_prox == S_VALIDAR)
         r_de_alarme <= (r_estado == S_ALARME);
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tent <= '0;
         r_niv  <= '0;
      end else if (r_estado == S_VALIDAR) begin
         if (w_prox == S_ENCOSTADA) begin
            r_tent <= '0;
            r_niv  <= '0;
         end else if ((w_prox == S_ERRADA) && (r_tent < 3'(MAX_TENT)))
            r_tent <= r_tent + 3'd1;
      end else if (w_fim_bloq) begin
         r_tent <= '0;
         if (r_niv < NIV_W'(BLOQ_MAX_SHIFT))
            r_niv <= r_niv + NIV_W'(1);
      end
   end

   // Slot writes only while the door stands open
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_SENHAS; i++)
            r_slots[i] <= '1;
      end else if (cfg_we && (r_estado == S_ABERTA) &&
                   (int'(cfg_idx) < NUM_SENHAS)) begin
         r_slots[cfg_idx] <= cfg_data;
      end
   end

   always_comb begin
      tranca     = 1'b0;
      bip        = 1'b0;
      teclado_en = 1'b0;
      bcd_pac    = BCD_VAZIO;
      case (r_estado)
         S_TRANCADA: begin
            tranca     = 1'b1;
            teclado_en = 1'b1;
         end
         S_VALIDAR:    tranca = 1'b1;
         S_ERRADA: begin
            tranca  = 1'b1;
            bcd_pac = w_tracos;
         end
         S_BLOQ: begin
            tranca  = 1'b1;
            bcd_pac = BCD_TRACO;
         end
         S_BIP_ABERTA: bip = 1'b1;
         S_BIP_INCOMP: begin
            tranca = 1'b1;
            bip    = 1'b1;
         end
         S_DEBOUNCE:   tranca = (r_origem != S_ENCOSTADA);
         S_NAO_PERT:   tranca = 1'b1;
`ifdef ALARME_INTRUSAO_EN
         S_ALARME: begin
            tranca     = 1'b1;
            bip        = 1'b1;
            teclado_en = 1'b1;
            bcd_pac    = BCD_TRACO;
         end
`endif
         default: ;
      endcase
   end

   assign tent = r_tent;

endmodule

// File: tb/tb_operacional_multi.sv
// Bench for operacional_multi: directed sequence with random codes,
// checked against a code-table / attempt / lockout reference model.
module tb_operacional_multi;

   localparam logic [15:0] MASTER = 16'h1234;
   localparam int MAX_TENT = 5;
   localparam int FECHAR_AUT = 100;
   localparam int BIPAR = 200;
   localparam int DURACAO_ERRO = 50;
   localparam int BLOQ_BASE = 1000;
   localparam int BLOQ_MAX_SHIFT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        sensor_contato;
   logic        botao_interno;
   logic        botao_bloqueio;
   logic [15:0] senha_value;
   logic        senha_valid;
   logic        cfg_we;
   logic [1:0]  cfg_idx;
   logic [15:0] cfg_data;
   logic        teclado_en;
   logic        tranca;
   logic        bip;
   logic [2:0]  tent;
   logic [23:0] bcd_pac;

   int checks = 0;
   int failures = 0;

   logic [15:0] m_slot [4];
   int m_tent;
   int m_niv;

   operacional_multi dut (
      .clk(clk), .rst(rst), .sensor_contato(sensor_contato),
      .botao_interno(botao_interno), .botao_bloqueio(botao_bloqueio),
      .senha_value(senha_value), .senha_valid(senha_valid),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
      .teclado_en(teclado_en), .tranca(tranca), .bip(bip),
      .tent(tent), .bcd_pac(bcd_pac)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_hit(input logic [15:0] c);
      if (c == MASTER) return 1'b1;
      for (int i = 0; i < 4; i++)
         if (m_slot[i] != 16'hFFFF && m_slot[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [23:0] m_dashes(input int t);
      logic [23:0] v;
      v = 24'hBBBBBB;
      for (int i = 0; i < t; i++) v[4*i +: 4] = 4'hA;
      return v;
   endfunction

   function automatic int m_bloq_len();
      int s;
      s = (m_niv > BLOQ_MAX_SHIFT) ? BLOQ_MAX_SHIFT : m_niv;
      return BLOQ_BASE * (1 << s);
   endfunction

   function automatic logic [15:0] codigo_errado();
      logic [15:0] c;
      do c = 16'($urandom); while (m_hit(c) || c[3:0] == 4'hE || c == 16'hFFFF);
      return c;
   endfunction

   task automatic autolock();
      int n;
      n = 0;
      while (tranca === 1'b0 && n < 5000) begin
         n++;
         step();
      end
      chk("autolock_ciclos", n, FECHAR_AUT);
      chk("autolock_teclado", teclado_en, 1);
   endtask

   task automatic tentar(input logic [15:0] c);
      bit hit;
      int n;
      hit = m_hit(c);
      senha_value = c;
      senha_valid = 1'b1;
      step();
      senha_valid = 1'b0;
      chk("validar_tranca", tranca, 1);
      step();
      if (hit) begin
         m_tent = 0;
         m_niv = 0;
         chk("acerto_tranca", tranca, 0);
         chk("acerto_tent", tent, 0);
      end else begin
         if (m_tent < MAX_TENT) m_tent++;
         chk("erro_bcd", bcd_pac, m_dashes(m_tent));
         chk("erro_tent", tent, m_tent);
         n = 0;
         while (bcd_pac === m_dashes(m_tent) && n < 1000) begin
            n++;
            step();
         end
         chk("erro_ciclos", n, DURACAO_ERRO);
         if (m_tent < MAX_TENT) begin
            chk("volta_teclado", teclado_en, 1);
            chk("volta_tranca", tranca, 1);
         end else begin
            chk("bloq_bcd", bcd_pac, 24'hAAAAAA);
            chk("bloq_teclado", teclado_en, 0);
            n = 0;
            while (bcd_pac === 24'hAAAAAA && n < 20000) begin
               n++;
               senha_value = MASTER;
               senha_valid = (n == 100);
               step();
            end
            senha_valid = 1'b0;
            chk("bloq_ciclos", n, m_bloq_len());
            m_tent = 0;
            if (m_niv < BLOQ_MAX_SHIFT) m_niv++;
            chk("bloq_saida_tent", tent, 0);
            chk("bloq_saida_teclado", teclado_en, 1);
         end
      end
   endtask

   initial begin
      logic [15:0] r0;
      logic [15:0] r3;
      int n;
      for (int i = 0; i < 4; i++) m_slot[i] = 16'hFFFF;
      m_tent = 0;
      m_niv = 0;
      rst = 1'b0;
      sensor_contato = 1'b1;
      botao_interno = 1'b0;
      botao_bloqueio = 1'b0;
      senha_value = '0;
      senha_valid = 1'b0;
      cfg_we = 1'b0;
      cfg_idx = '0;
      cfg_data = '0;
      step(2);
      chk("rst_tranca", tranca, 0);
      chk("rst_bip", bip, 0);
      chk("rst_teclado", teclado_en, 0);
      chk("rst_bcd", bcd_pac, 24'hBBBBBB);
      chk("rst_tent", tent, 0);
      rst = 1'b1;
      step();
      chk("espera_sensor", tranca, 0);
      sensor_contato = 1'b0;
      step();
      chk("trancada_tranca", tranca, 1);
      chk("trancada_bip", bip, 0);
      chk("trancada_teclado", teclado_en, 1);

      tentar(MASTER);
      autolock();

      repeat (MAX_TENT) tentar(codigo_errado());
      repeat (MAX_TENT) tentar(codigo_errado());
      tentar(MASTER);
      autolock();

      tentar(codigo_errado());
      senha_value = {12'($urandom), 4'hE};
      senha_valid = 1'b1;
      step();
      senha_valid = 1'b0;
      chk("incomp_tranca", tranca, 1);
      n = 0;
      while (bip === 1'b1 && n < 1000) begin
         n++;
         step();
      end
      chk("incomp_ciclos", n, DURACAO_ERRO);
      chk("incomp_tent", tent, m_tent);
      chk("incomp_teclado", teclado_en, 1);
      repeat (MAX_TENT - 1) tentar(codigo_errado());

      botao_interno = 1'b1;
      step(2);
      chk("deb_curto_meio", tranca, 1);
      step(3);
      botao_interno = 1'b0;
      step(3);
      chk("deb_curto_tranca", tranca, 1);
      chk("deb_curto_teclado", teclado_en, 1);

      botao_bloqueio = 1'b1;
      step(11);
      botao_bloqueio = 1'b0;
      step();
      chk("np_tranca", tranca, 1);
      chk("np_teclado", teclado_en, 0);
      botao_interno = 1'b1;
      step(11);
      botao_interno = 1'b0;
      chk("np_abre", tranca, 0);
      autolock();

      do r3 = codigo_errado(); while (r3 == 16'h9876);
      botao_interno = 1'b1;
      step(11);
      botao_interno = 1'b0;
      chk("deb_longo_tranca", tranca, 0);
      sensor_contato = 1'b1;
      step();
      n = 0;
      while (bip === 1'b0 && tranca === 1'b0 && n < 1000) begin
         n++;
         step();
      end
      chk("aberta_ciclos", n, BIPAR);
      chk("bip_aberta", bip, 1);
      sensor_contato = 1'b0;
      cfg_we = 1'b1;
      cfg_idx = 2'd3;
      cfg_data = r3;
      step();
      cfg_we = 1'b0;
      chk("fecha_bip", bip, 0);
      autolock();

      tentar(MASTER);
      do r0 = codigo_errado(); while (r0 == 16'h9876 || r0 == r3);
      sensor_contato = 1'b1;
      step();
      cfg_we = 1'b1;
      cfg_idx = 2'd0;
      cfg_data = r0;
      step();
      m_slot[0] = r0;
      cfg_idx = 2'd2;
      cfg_data = 16'h9876;
      sensor_contato = 1'b0;
      step();
      m_slot[2] = 16'h9876;
      cfg_we = 1'b0;
      autolock();

      tentar(16'h9876);
      autolock();
      tentar(r0);
      autolock();
      tentar(r3);
      tentar(MASTER);
      autolock();

`ifdef ALARME_INTRUSAO_EN
      sensor_contato = 1'b1;
      step();
      chk("alarme_bip", bip, 1);
      chk("alarme_bcd", bcd_pac, 24'hAAAAAA);
      sensor_contato = 1'b0;
      senha_value = codigo_errado();
      senha_valid = 1'b1;
      step();
      senha_valid = 1'b0;
      step(2);
      chk("alarme_erro_bip", bip, 1);
      senha_value = MASTER;
      senha_valid = 1'b1;
      step();
      senha_valid = 1'b0;
      step();
      chk("alarme_sai_bip", bip, 0);
      chk("alarme_sai_tranca", tranca, 0);
      autolock();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
